// File: rtl/scc_pkg.sv
// Shared SCC core definitions: wave RAM bank numbers, address width, owner tags.
// Used by scc_wave_ram_arbiter (optional stats build: SCC_WAVE_ARB_STATS_EN).
package scc_pkg;

    localparam logic [2:0] SCC_BANK_A = 3'd0;
    localparam logic [2:0] SCC_BANK_B = 3'd1;
    localparam logic [2:0] SCC_BANK_C = 3'd2;
    localparam logic [2:0] SCC_BANK_D = 3'd3;
    localparam logic [2:0] SCC_BANK_E = 3'd4;

    localparam int unsigned SCC_WAVE_AW = 8;

    typedef enum logic {
        OWN_MIX = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_MIX,
        GRANT_CPU
    } grant_e;

    // Plain SCC has four banks: channel E shares bank D.
    function automatic logic [SCC_WAVE_AW-1:0] scc_map_addr(
        input logic       scci,
        input logic [2:0] id,
        input logic [4:0] a
    );
        logic [2:0] bank;
        bank = (!scci && id == SCC_BANK_E) ? SCC_BANK_D : id;
        return {bank, a};
    endfunction

endpackage

// File: rtl/scc_wave_ram_arbiter.sv
// Wave RAM arbiter: mixer-priority sharing of the SCC wave SRAM with a CPU wait guard.
// Define SCC_WAVE_ARB_STATS_EN to add the stat_conflict / stat_override counters.
module scc_wave_ram_arbiter
    import scc_pkg::*;
#(
    parameter int unsigned CPU_MAX_WAIT = 2,
    parameter int unsigned RAM_AW       = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              scci_mode,
    input  logic              mix_req,
    input  logic [2:0]        mix_id,
    input  logic [4:0]        mix_a,
    output logic              mix_ack,
    output logic [7:0]        mix_q,
    output logic              mix_q_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_id,
    input  logic [4:0]        cpu_a,
    input  logic [7:0]        cpu_d,
    output logic              cpu_ack,
    output logic [7:0]        cpu_q,
    output logic              cpu_q_en,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_d,
    output logic              ram_oe,
    output logic              ram_we,
    input  logic [7:0]        ram_q
`ifdef SCC_WAVE_ARB_STATS_EN
   ,output logic [15:0]       stat_conflict,
    output logic [15:0]       stat_override
`endif
);

    localparam logic [2:0] WAIT_MAX = 3'(CPU_MAX_WAIT);

    logic       mix_el;
    logic       cpu_el;
    logic       guard;
    grant_e     grant;
    logic [2:0] wait_cnt;
    tag_t       issue_tag;
    tag_t       ret_tag;
    logic [7:0] mix_q_hold;
    logic [7:0] cpu_q_hold;

    // A requester whose ack is showing this cycle is masked so it cannot win twice in a row.
    always_comb begin
        mix_el = mix_req & ~mix_ack;
        cpu_el = cpu_req & ~cpu_ack;
        guard  = cpu_el && (wait_cnt == WAIT_MAX);
        grant  = GRANT_NONE;
        if (guard) begin
            grant = GRANT_CPU;
        end else if (mix_el) begin
            grant = GRANT_MIX;
        end else if (cpu_el) begin
            grant = GRANT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            mix_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            ram_oe    <= 1'b0;
            ram_we    <= 1'b0;
            issue_tag <= '0;
            ret_tag   <= '0;
            wait_cnt  <= '0;
        end else begin
            mix_ack <= (grant == GRANT_MIX);
            cpu_ack <= (grant == GRANT_CPU);
            case (grant)
                GRANT_MIX: begin
                    ram_a     <= scc_map_addr(scci_mode, mix_id, mix_a);
                    ram_d     <= '0;
                    ram_oe    <= 1'b1;
                    ram_we    <= 1'b0;
                    issue_tag <= '{valid: 1'b1, owner: OWN_MIX};
                end
                GRANT_CPU: begin
                    ram_a     <= scc_map_addr(scci_mode, cpu_id, cpu_a);
                    ram_d     <= cpu_we ? cpu_d : '0;
                    ram_oe    <= ~cpu_we;
                    ram_we    <= cpu_we;
                    issue_tag <= '{valid: ~cpu_we, owner: OWN_CPU};
                end
                default: begin
                    ram_a     <= '0;
                    ram_d     <= '0;
                    ram_oe    <= 1'b0;
                    ram_we    <= 1'b0;
                    issue_tag <= '0;
                end
            endcase
            ret_tag <= issue_tag;

            if (!cpu_req || grant == GRANT_CPU) begin
                wait_cnt <= '0;
            end else if (cpu_el && grant == GRANT_MIX && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

    // Read data is steered straight from the RAM; the idle side shows its last value.
    always_comb begin
        mix_q_en = ret_tag.valid && (ret_tag.owner == OWN_MIX);
        cpu_q_en = ret_tag.valid && (ret_tag.owner == OWN_CPU);
        mix_q    = mix_q_en ? ram_q : mix_q_hold;
        cpu_q    = cpu_q_en ? ram_q : cpu_q_hold;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            mix_q_hold <= '0;
            cpu_q_hold <= '0;
        end else begin
            if (mix_q_en) mix_q_hold <= ram_q;
            if (cpu_q_en) cpu_q_hold <= ram_q;
        end
    end

`ifdef SCC_WAVE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_conflict <= '0;
            stat_override <= '0;
        end else begin
            if (mix_el && cpu_el && stat_conflict != '1) stat_conflict <= stat_conflict + 16'd1;
            if (guard && stat_override != '1) stat_override <= stat_override + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scc_wave_ram_arbiter.sv
// Bench for scc_wave_ram_arbiter: vector table + arbitration model + read-data scoreboard.
// Stats counters are checked when built with SCC_WAVE_ARB_STATS_EN.
module tb_scc_wave_ram_arbiter;

    logic       clk;
    logic       nreset;
    logic       scci_mode;
    logic       mix_req;
    logic [2:0] mix_id;
    logic [4:0] mix_a;
    logic       mix_ack;
    logic [7:0] mix_q;
    logic       mix_q_en;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_id;
    logic [4:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_ack;
    logic [7:0] cpu_q;
    logic       cpu_q_en;
    logic [7:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_oe;
    logic       ram_we;
    logic [7:0] ram_q;
`ifdef SCC_WAVE_ARB_STATS_EN
    logic [15:0] stat_conflict;
    logic [15:0] stat_override;
`endif

    scc_wave_ram_arbiter #(.CPU_MAX_WAIT(2), .RAM_AW(8)) dut (
        .clk(clk), .nreset(nreset), .scci_mode(scci_mode),
        .mix_req(mix_req), .mix_id(mix_id), .mix_a(mix_a),
        .mix_ack(mix_ack), .mix_q(mix_q), .mix_q_en(mix_q_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_id(cpu_id), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q), .cpu_q_en(cpu_q_en),
        .ram_a(ram_a), .ram_d(ram_d), .ram_oe(ram_oe), .ram_we(ram_we), .ram_q(ram_q)
`ifdef SCC_WAVE_ARB_STATS_EN
       ,.stat_conflict(stat_conflict), .stat_override(stat_override)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] mix_exp [$];
    logic [7:0] cpu_exp [$];
    int m_conf;
    int m_ovr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port SRAM model: read data appears the cycle after ram_oe.
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        if (ram_oe) ram_q <= mem[ram_a];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mix_q_en === 1'b1) begin
            if (mix_exp.size() == 0) check("mix_q_en unexpected", 1, 0);
            else check("mix_q data", {56'd0, mix_q}, {56'd0, mix_exp.pop_front()});
        end
        if (cpu_q_en === 1'b1) begin
            if (cpu_exp.size() == 0) check("cpu_q_en unexpected", 1, 0);
            else check("cpu_q data", {56'd0, cpu_q}, {56'd0, cpu_exp.pop_front()});
        end
    end

    function automatic logic [7:0] tb_addr(input logic scci, input logic [2:0] id, input logic [4:0] a);
        logic [2:0] b;
        b = id;
        if (!scci && id == 3'd4) b = 3'd3;
        return {b, a};
    endfunction

    function automatic logic [37:0] all_outs();
        return {mix_ack, mix_q, mix_q_en, cpu_ack, cpu_q, cpu_q_en, ram_a, ram_d, ram_oe, ram_we};
    endfunction

    typedef struct {
        logic       scci;
        logic       men;
        logic [2:0] mid;
        logic [4:0] ma;
        logic       cen;
        logic       cwe;
        logic [2:0] cid;
        logic [4:0] ca;
        logic [7:0] cd;
        int         ncyc;
        logic [7:0] exp_a;
    } vec_t;

    vec_t tbl [10];

    // Hold the requests for v.ncyc cycles while a cycle model predicts every ack.
    task automatic run_vec(input vec_t v, input int idx);
        logic       m_mack = 1'b0;
        logic       m_cack = 1'b0;
        logic [2:0] m_wait = 3'd0;
        logic [7:0] pm_a = 8'd0;
        logic [7:0] pc_a = 8'd0;
        logic [7:0] pc_d = 8'd0;
        logic       pc_we = 1'b0;
        logic       mel, cel, grd, wmix, wcpu;
        bit         first = 1'b1;
        @(posedge clk); #1;
        scci_mode = v.scci;
        mix_req = v.men; mix_id = v.mid; mix_a = v.ma;
        cpu_req = v.cen; cpu_we = v.cwe; cpu_id = v.cid; cpu_a = v.ca; cpu_d = v.cd;
        for (int cyc = 0; cyc <= v.ncyc; cyc++) begin
            @(negedge clk);
            check($sformatf("v%0d c%0d mix_ack", idx, cyc), mix_ack, m_mack);
            check($sformatf("v%0d c%0d cpu_ack", idx, cyc), cpu_ack, m_cack);
            if (m_mack || m_cack) begin
                if (first) check($sformatf("v%0d first ram_a", idx), ram_a, v.exp_a);
                first = 1'b0;
            end
            if (m_mack) begin
                check($sformatf("v%0d mix ram_a", idx), ram_a, pm_a);
                check($sformatf("v%0d mix oe/we", idx), {ram_oe, ram_we}, 2'b10);
                mix_exp.push_back(shadow[pm_a]);
            end
            if (m_cack) begin
                check($sformatf("v%0d cpu ram_a", idx), ram_a, pc_a);
                check($sformatf("v%0d cpu oe/we", idx), {ram_oe, ram_we}, {~pc_we, pc_we});
                if (pc_we) begin
                    check($sformatf("v%0d cpu ram_d", idx), ram_d, pc_d);
                    shadow[pc_a] = pc_d;
                end else begin
                    cpu_exp.push_back(shadow[pc_a]);
                end
            end
            if (cyc == v.ncyc - 1) begin
                mix_req = 1'b0;
                cpu_req = 1'b0;
            end
            mel  = mix_req && !m_mack;
            cel  = cpu_req && !m_cack;
            grd  = cel && (m_wait == 3'd2);
            wcpu = grd || (cel && !mel);
            wmix = mel && !grd;
            if (mel && cel) m_conf++;
            if (grd) m_ovr++;
            if (!cpu_req || wcpu) m_wait = 3'd0;
            else if (cel && wmix && m_wait != 3'd2) m_wait = m_wait + 3'd1;
            pm_a  = tb_addr(scci_mode, mix_id, mix_a);
            pc_a  = tb_addr(scci_mode, cpu_id, cpu_a);
            pc_we = cpu_we;
            pc_d  = cpu_d;
            m_mack = wmix;
            m_cack = wcpu;
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d mix scoreboard drained", idx), mix_exp.size(), 0);
        check($sformatf("v%0d cpu scoreboard drained", idx), cpu_exp.size(), 0);
        mix_exp.delete();
        cpu_exp.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           scci men mid   ma     cen cwe cid   ca     cd     ncyc exp_a
        tbl[0] = '{1'b1, 1'b1, 3'd2, 5'h05, 1'b0, 1'b0, 3'd0, 5'h00, 8'h00, 2, 8'h45};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 5'h00, 1'b1, 1'b1, 3'd4, 5'h1F, 8'hA5, 2, 8'h7F};
        tbl[2] = '{1'b0, 1'b1, 3'd4, 5'h1F, 1'b0, 1'b0, 3'd0, 5'h00, 8'h00, 2, 8'h7F};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 5'h00, 1'b1, 1'b0, 3'd4, 5'h1F, 8'h00, 2, 8'h9F};
        tbl[4] = '{1'b1, 1'b1, 3'd6, 5'h03, 1'b0, 1'b0, 3'd0, 5'h00, 8'h00, 2, 8'hC3};
        tbl[5] = '{1'b1, 1'b0, 3'd0, 5'h00, 1'b1, 1'b1, 3'd3, 5'h1F, 8'h5A, 2, 8'h7F};
        tbl[6] = '{1'b0, 1'b0, 3'd0, 5'h00, 1'b1, 1'b0, 3'd4, 5'h1F, 8'h00, 2, 8'h7F};
        tbl[7] = '{1'b1, 1'b1, 3'd0, 5'h01, 1'b1, 1'b0, 3'd1, 5'h02, 8'h00, 10, 8'h01};
        tbl[8] = '{1'b1, 1'b1, 3'd2, 5'h10, 1'b1, 1'b1, 3'd2, 5'h10, 8'hEE, 4, 8'h50};
        tbl[9] = '{1'b0, 1'b1, 3'd4, 5'h00, 1'b1, 1'b1, 3'd3, 5'h00, 8'h77, 4, 8'h60};

        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'((i * 7 + 3) & 255);
            shadow[i] = 8'((i * 7 + 3) & 255);
        end
        mem[8'h45]    = 8'h3C;
        shadow[8'h45] = 8'h3C;
        ram_q = 8'h00;

        nreset = 1'b0; scci_mode = 1'b1;
        mix_req = 1'b0; mix_id = '0; mix_a = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_id = '0; cpu_a = '0; cpu_d = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {26'd0, all_outs()}, 64'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset arrives while a granted mixer read is in flight.
        @(posedge clk); #1;
        mix_id = 3'd1; mix_a = 5'h02; mix_req = 1'b1;
        @(negedge clk);
        check("rst seq mix_ack before", mix_ack, 1'b0);
        @(negedge clk);
        check("rst seq mix_ack", mix_ack, 1'b1);
        mix_req = 1'b0;
        nreset  = 1'b0;
        @(negedge clk);
        check("rst seq outputs zero", {26'd0, all_outs()}, 64'd0);
        nreset = 1'b1;
        m_conf = 0;
        m_ovr  = 0;
        @(negedge clk);
        check("rst seq no mix_q_en", mix_q_en, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

`ifdef SCC_WAVE_ARB_STATS_EN
        check("stat_conflict", {48'd0, stat_conflict}, 64'(m_conf));
        check("stat_override", {48'd0, stat_override}, 64'(m_ovr));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
